// File: rtl/fft_result_buf.sv
// fft_result_buf: readback buffer for FFT accelerator results.
// The accelerator deposits a whole frame in one cycle. The CPU then drains it
// word by word over an en/we/addr bus. The buffer releases itself once every
// word has been read, or when the CPU writes a release to the control word.
// Optional build macro FFT_RESULT_PACK_EN: when defined, two 16-bit words are
// packed into each 32-bit read, so a frame drains in 16 reads.
module fft_result_buf #(
    parameter int MEMWIDTH  = 32,
    parameter int WORDWIDTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          accel_done_i,
    input  logic [MEMWIDTH*WORDWIDTH-1:0] accel_data_i,
    output logic                          accel_busy_o,
    input  logic                          en_i,
    input  logic                          we_i,
    input  logic [5:0]                    addr_i,
    input  logic [31:0]                   data_i,
    output logic [31:0]                   data_o,
    output logic                          irq_o
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t                state_q, state_d;
    logic [WORDWIDTH-1:0]  mem_q [MEMWIDTH];
    logic [MEMWIDTH-1:0]   mask_q, mask_d, readBits;
    logic                  overrun_q, overrun_d;
    logic [31:0]           data_q, data_d, readData;
    logic                  busy_q, irq_q;
    logic                  isRead, ctrlWrite, relWrite, clrOv, capture;
    logic                  unusedBits;

    assign unusedBits = ^data_i[31:2];

    function automatic logic [5:0] countMask(input logic [MEMWIDTH-1:0] m);
        logic [5:0] c;
        c = '0;
        for (int i = 0; i < MEMWIDTH; i++) begin
            c = c + 6'(m[i]);
        end
        return c;
    endfunction

    // Decode the CPU access, pick the read data and compute next state, mask and overrun.
    always_comb begin
        isRead    = en_i && !we_i;
        ctrlWrite = en_i && we_i && (addr_i == 6'd32);
        relWrite  = ctrlWrite && data_i[0];
        clrOv     = ctrlWrite && data_i[1];
        capture   = accel_done_i && (state_q == EMPTY) && !relWrite;

        readBits  = '0;
        readData  = '0;
`ifdef FFT_RESULT_PACK_EN
        if (addr_i < 6'd16) begin
            readData = 32'({mem_q[{addr_i[3:0], 1'b1}], mem_q[{addr_i[3:0], 1'b0}]});
            readBits[{addr_i[3:0], 1'b0}] = 1'b1;
            readBits[{addr_i[3:0], 1'b1}] = 1'b1;
        end else if (addr_i == 6'd32) begin
`else
        if (addr_i < 6'd32) begin
            readData = 32'(signed'(mem_q[addr_i[4:0]]));
            readBits[addr_i[4:0]] = 1'b1;
        end else if (addr_i == 6'd32) begin
`endif
            readData = {18'd0, countMask(mask_q), 6'd0, overrun_q, state_q == FULL};
        end

        mask_d = mask_q;
        if (isRead && (state_q == FULL)) begin
            mask_d = mask_q | readBits;
        end

        state_d = state_q;
        if (relWrite) begin
            state_d = EMPTY;
            mask_d  = '0;
        end else if ((state_q == FULL) && (&mask_q)) begin
            state_d = EMPTY;
            mask_d  = '0;
        end else if (capture) begin
            state_d = FULL;
        end

        overrun_d = overrun_q;
        if (clrOv) begin
            overrun_d = 1'b0;
        end
        if (accel_done_i && !capture) begin
            overrun_d = 1'b1;
        end

        data_d = isRead ? readData : data_q;
    end

    // State, storage, mask, overrun and registered outputs, with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= EMPTY;
            mask_q    <= '0;
            overrun_q <= 1'b0;
            data_q    <= '0;
            busy_q    <= 1'b0;
            irq_q     <= 1'b0;
            for (int k = 0; k < MEMWIDTH; k++) begin
                mem_q[k] <= '0;
            end
        end else begin
            state_q   <= state_d;
            mask_q    <= mask_d;
            overrun_q <= overrun_d;
            data_q    <= data_d;
            busy_q    <= (state_d == FULL);
            irq_q     <= (state_d == FULL);
            if (capture) begin
                for (int k = 0; k < MEMWIDTH; k++) begin
                    mem_q[k] <= accel_data_i[k*WORDWIDTH +: WORDWIDTH];
                end
            end
        end
    end

    assign accel_busy_o = busy_q;
    assign irq_o        = irq_q;
    assign data_o       = data_q;

endmodule

// File: tb/tb_fft_result_buf.sv
// tb_fft_result_buf: directed self-checking bench for fft_result_buf.
// Build with +define+FFT_RESULT_PACK_EN to exercise the packed-read variant.
module tb_fft_result_buf;

    logic         clk;
    logic         rst;
    logic         accelDone;
    logic [511:0] accelData;
    logic         accelBusy;
    logic         enI;
    logic         weI;
    logic [5:0]   addrI;
    logic [31:0]  dataI;
    logic [31:0]  dataO;
    logic         irqO;

    int checks;
    int errors;

    logic [511:0] frameA;
    logic [511:0] frameB;

    fft_result_buf #(.MEMWIDTH(32), .WORDWIDTH(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .accel_done_i (accelDone),
        .accel_data_i (accelData),
        .accel_busy_o (accelBusy),
        .en_i         (enI),
        .we_i         (weI),
        .addr_i       (addrI),
        .data_i       (dataI),
        .data_o       (dataO),
        .irq_o        (irqO)
    );

    // Free-running clock, 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [511:0] makeFrame(input logic [15:0] base);
        logic [511:0] f;
        f = '0;
        for (int k = 0; k < 32; k++) begin
            f[k*16 +: 16] = base + 16'(k);
        end
        return f;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic en, input logic we, input logic [5:0] addr,
                                 input logic [31:0] data, input logic done,
                                 input logic [511:0] frame);
        enI       = en;
        weI       = we;
        addrI     = addr;
        dataI     = data;
        accelDone = done;
        accelData = frame;
        tick();
        enI       = 1'b0;
        weI       = 1'b0;
        accelDone = 1'b0;
    endtask

    task automatic readAddr(input logic [5:0] addr);
        applyStimulus(1'b1, 1'b0, addr, 32'd0, 1'b0, '0);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Linear sequence of directed steps.
    initial begin
        checks    = 0;
        errors    = 0;
        frameA    = makeFrame(16'h8000);
        frameB    = makeFrame(16'h1000);
        rst       = 1'b0;
        enI       = 1'b0;
        weI       = 1'b0;
        addrI     = '0;
        dataI     = '0;
        accelDone = 1'b0;
        accelData = '0;
        tick();
        tick();
        rst = 1'b1;

        checkOutput("resetData", dataO, 32'h0);
        checkOutput("resetIrq", {31'd0, irqO}, 32'h0);
        checkOutput("resetBusy", {31'd0, accelBusy}, 32'h0);
        readAddr(6'd32);
        checkOutput("resetStatus", dataO, 32'h0);

        applyStimulus(1'b0, 1'b0, 6'd0, 32'd0, 1'b1, frameA);
        checkOutput("captureBusy", {31'd0, accelBusy}, 32'h1);
        checkOutput("captureIrq", {31'd0, irqO}, 32'h1);

`ifdef FFT_RESULT_PACK_EN
        readAddr(6'd3);
        checkOutput("packWord3", dataO, 32'h80078006);
        readAddr(6'd32);
        checkOutput("packStatus", dataO, 32'h00000201);
        readAddr(6'd20);
        checkOutput("packHighZero", dataO, 32'h0);
        readAddr(6'd32);
        checkOutput("packStatusHigh", dataO, 32'h00000201);
        for (int k = 0; k < 16; k++) begin
            readAddr(6'(k));
            checkOutput("packDrain", dataO,
                        {16'h8001 + 16'(2*k), 16'h8000 + 16'(2*k)});
        end
        readAddr(6'd32);
        checkOutput("packDrainStatus", dataO, 32'h00002001);
        checkOutput("packDrainBusy", {31'd0, accelBusy}, 32'h0);
        checkOutput("packDrainIrq", {31'd0, irqO}, 32'h0);
        applyStimulus(1'b0, 1'b0, 6'd0, 32'd0, 1'b1, frameB);
        checkOutput("packRecapture", {31'd0, accelBusy}, 32'h1);
`else
        readAddr(6'd0);
        checkOutput("word0", dataO, 32'hFFFF8000);
        readAddr(6'd31);
        checkOutput("word31", dataO, 32'hFFFF801F);
        readAddr(6'd32);
        checkOutput("statusTwo", dataO, 32'h00000201);

        applyStimulus(1'b1, 1'b1, 6'd32, 32'h1, 1'b0, '0);
        checkOutput("releaseBusy", {31'd0, accelBusy}, 32'h0);
        checkOutput("writeHoldsData", dataO, 32'h00000201);

        applyStimulus(1'b0, 1'b0, 6'd0, 32'd0, 1'b1, frameA);
        for (int k = 0; k < 32; k++) begin
            readAddr(6'(k));
            checkOutput("drainWord", dataO, 32'hFFFF8000 + 32'(k));
            readAddr(6'd32);
            checkOutput("drainStatus", dataO, (32'(k + 1) << 8) | 32'h1);
        end
        checkOutput("drainBusy", {31'd0, accelBusy}, 32'h0);
        checkOutput("drainIrq", {31'd0, irqO}, 32'h0);
        readAddr(6'd32);
        checkOutput("drainStatusEmpty", dataO, 32'h0);

        applyStimulus(1'b0, 1'b0, 6'd0, 32'd0, 1'b1, frameA);
        for (int r = 0; r < 3; r++) begin
            readAddr(6'd5);
            checkOutput("reread5", dataO, 32'hFFFF8005);
        end
        readAddr(6'd32);
        checkOutput("rereadStatus", dataO, 32'h00000101);
        applyStimulus(1'b0, 1'b0, 6'd0, 32'd0, 1'b1, frameB);
        readAddr(6'd32);
        checkOutput("overrunStatus", dataO, 32'h00000103);
        applyStimulus(1'b1, 1'b1, 6'd32, 32'h2, 1'b0, '0);
        checkOutput("clearHoldsData", dataO, 32'h00000103);
        readAddr(6'd32);
        checkOutput("clearStatus", dataO, 32'h00000101);
        readAddr(6'd6);
        checkOutput("storageKept", dataO, 32'hFFFF8006);
        readAddr(6'd40);
        checkOutput("unmappedZero", dataO, 32'h0);

        applyStimulus(1'b1, 1'b1, 6'd32, 32'h1, 1'b1, frameB);
        checkOutput("collideBusy", {31'd0, accelBusy}, 32'h0);
        readAddr(6'd32);
        checkOutput("collideStatus", dataO, 32'h00000002);
        readAddr(6'd6);
        checkOutput("collideStorage", dataO, 32'hFFFF8006);
        readAddr(6'd32);
        checkOutput("emptyReadNoMask", dataO, 32'h00000002);

        applyStimulus(1'b1, 1'b0, 6'd7, 32'd0, 1'b1, frameB);
        checkOutput("preCaptureRead", dataO, 32'hFFFF8007);
        checkOutput("concurrentCapture", {31'd0, accelBusy}, 32'h1);
        readAddr(6'd7);
        checkOutput("newFrameWord7", dataO, 32'h00001007);
        readAddr(6'd32);
        checkOutput("newFrameStatus", dataO, 32'h00000103);
`endif

        rst = 1'b0;
        readAddr(6'd7);
        rst = 1'b1;
        checkOutput("midResetData", dataO, 32'h0);
        checkOutput("midResetIrq", {31'd0, irqO}, 32'h0);
        checkOutput("midResetBusy", {31'd0, accelBusy}, 32'h0);
        readAddr(6'd32);
        checkOutput("midResetStatus", dataO, 32'h0);
        readAddr(6'd7);
        checkOutput("midResetStorage", dataO, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
